// File: rtl/tlul_pkg.sv
// ============================================================================
// Module : tlul_pkg
// Brief  : Shared widths, integrity word type and occupancy states for the
//          TL-UL data-integrity encode buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

  localparam int DataMaxWidth  = 32;
  localparam int DataIntgWidth = 7;
  localparam int DataWordWidth = DataMaxWidth + DataIntgWidth;

  // {7-bit check, 32-bit data}
  typedef logic [DataWordWidth-1:0] tlul_intg_word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage : tlul_pkg

`default_nettype wire

// File: rtl/prim_secded_inv_39_32_enc.sv
// ============================================================================
// Module : prim_secded_inv_39_32_enc
// Brief  : Inverted Hsiao 39/32 SECDED encoder (check bits XOR 7'h2A).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prim_secded_inv_39_32_enc
  import tlul_pkg::*;
(
  input  logic [DataMaxWidth-1:0] data_i,
  output tlul_intg_word_t         data_o
);

  localparam logic [DataIntgWidth-1:0] c_inv_mask = 7'h2A;

  // Row i selects the data bits that feed check bit i.
  localparam logic [DataMaxWidth-1:0] c_chk_mask [DataIntgWidth] = '{
    32'h2606BD25,
    32'hDEBA8050,
    32'h413D89AA,
    32'h31234ED1,
    32'hC2C1323B,
    32'h2DCC624C,
    32'h98505586
  };

  logic [DataIntgWidth-1:0] w_chk;

  always_comb begin
    w_chk = '0;
    for (int i = 0; i < DataIntgWidth; i++) begin
      w_chk[i] = ^(data_i & c_chk_mask[i]);
    end
  end

  assign data_o = {w_chk ^ c_inv_mask, data_i};

endmodule : prim_secded_inv_39_32_enc

`default_nettype wire

// File: rtl/tlul_data_integ_enc_buf.sv
// ============================================================================
// Module : tlul_data_integ_enc_buf
// Brief  : Encodes accepted words with inverted SECDED at capture and buffers
//          them (Depth=1 pipeline register, Depth=2 skid buffer).
//          Optional macro TLUL_DATA_INTEG_ERR_INJ_EN enables error injection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlul_data_integ_enc_buf
  import tlul_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DataMaxWidth-1:0] in_data_i,
  input  logic [1:0]              inj_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output tlul_intg_word_t         out_data_intg_o,
  output logic                    busy_o
);

  tlul_intg_word_t w_enc;
  tlul_intg_word_t w_inj_mask;
  tlul_intg_word_t w_cap;
  logic            w_push;
  logic            w_pop;

  prim_secded_inv_39_32_enc u_enc (
    .data_i (in_data_i),
    .data_o (w_enc)
  );

`ifdef TLUL_DATA_INTEG_ERR_INJ_EN
  always_comb begin
    w_inj_mask = '0;
    case (inj_i)
      2'b01:   w_inj_mask[0]   = 1'b1;
      2'b11:   w_inj_mask[1:0] = 2'b11;
      2'b10:   w_inj_mask[32]  = 1'b1;
      default: w_inj_mask      = '0;
    endcase
  end
`else
  logic w_unused_inj;
  assign w_unused_inj = ^inj_i;
  assign w_inj_mask   = '0;
`endif

  assign w_cap  = w_enc ^ w_inj_mask;
  assign w_push = in_valid_i && in_ready_o;
  assign w_pop  = out_valid_o && out_ready_i;
  assign busy_o = out_valid_o;

  generate
    if (Depth == 1) begin : g_pipe
      occ_state_e      r_state;
      tlul_intg_word_t r_data;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_state <= OCC_EMPTY;
          r_data  <= '0;
        end else if (w_push) begin
          // A push during a pop simply overwrites the departing entry.
          r_state <= OCC_ONE;
          r_data  <= w_cap;
        end else if (w_pop) begin
          r_state <= OCC_EMPTY;
        end
      end

      assign in_ready_o      = (r_state == OCC_EMPTY) || out_ready_i;
      assign out_valid_o     = (r_state != OCC_EMPTY);
      assign out_data_intg_o = r_data;
    end else begin : g_skid
      occ_state_e      r_state;
      logic            r_head;
      logic            r_tail;
      logic            r_in_ready;
      tlul_intg_word_t r_mem0;
      tlul_intg_word_t r_mem1;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_state    <= OCC_EMPTY;
          r_head     <= 1'b0;
          r_tail     <= 1'b0;
          r_in_ready <= 1'b1;
          r_mem0     <= '0;
          r_mem1     <= '0;
        end else begin
          if (w_push) begin
            if (r_tail) r_mem1 <= w_cap;
            else        r_mem0 <= w_cap;
            r_tail <= ~r_tail;
          end
          if (w_pop) r_head <= ~r_head;

          // in_ready is registered, so a pop while full frees space one cycle later.
          case (r_state)
            OCC_EMPTY: if (w_push) r_state <= OCC_ONE;
            OCC_ONE: begin
              if (w_push && !w_pop) begin
                r_state    <= OCC_FULL;
                r_in_ready <= 1'b0;
              end else if (!w_push && w_pop) begin
                r_state <= OCC_EMPTY;
              end
            end
            OCC_FULL: begin
              if (w_pop) begin
                r_state    <= OCC_ONE;
                r_in_ready <= 1'b1;
              end
            end
            default: begin
              r_state    <= OCC_EMPTY;
              r_in_ready <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready_o      = r_in_ready;
      assign out_valid_o     = (r_state != OCC_EMPTY);
      assign out_data_intg_o = r_head ? r_mem1 : r_mem0;
    end
  endgenerate

endmodule : tlul_data_integ_enc_buf

`default_nettype wire

// File: doc/tlul_data_integ_enc_buf.md
TLUL_DATA_INTEG_ENC_BUF -- requirements
Module: tlul_data_integ_enc_buf

Interface
REQ-001 SHALL have parameter Depth, default 2, buffer entries; legal values 1 (pipeline register) or 2 (skid buffer).
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid_i, input, 1, upstream data valid.
REQ-005 SHALL have port in_ready_o, output, 1, block accepts upstream data.
REQ-006 SHALL have port in_data_i, input, DataMaxWidth (32), raw payload.
REQ-007 SHALL have port inj_i, input, 2, error-injection request, sampled with in_data_i.
REQ-008 SHALL have port out_valid_o, output, 1, encoded word available.
REQ-009 SHALL have port out_ready_i, input, 1, downstream accepts.
REQ-010 SHALL have port out_data_intg_o, output, DataMaxWidth+DataIntgWidth (39), {7-bit check, 32-bit data}.
REQ-011 SHALL have port busy_o, output, 1, high when any entry holds data.

Function
REQ-012 SHALL encode each accepted word with the inverted 39/32 SECDED code: check bits = standard Hsiao 39/32 check bits XOR 7'h2A.
REQ-013 SHALL encode at capture; stored entries hold the full 39-bit word, so out_data_intg_o is a register output with no combinational path from in_data_i.
REQ-014 SHALL transfer upstream when in_valid_i && in_ready_o, downstream when out_valid_o && out_ready_i.
REQ-015 SHALL deliver words in acceptance order, no loss, no duplication.
REQ-016 Depth=1: in_ready_o = !full || out_ready_i; simultaneous pop and push in the same cycle SHALL replace the entry; minimum latency 1 cycle.
REQ-017 Depth=2: in_ready_o SHALL be a register output, high iff fewer than 2 entries valid; head/tail pointers 1-bit, wrap 1->0.
REQ-018 Depth=2 full with simultaneous pop: push SHALL NOT occur (in_ready_o low); count goes 2->1.
REQ-019 Depth=2 with 1 entry, simultaneous push and pop: count stays 1, new word becomes head next cycle.
REQ-020 out_valid_o SHALL equal (count != 0); out_data_intg_o SHALL show the head entry and be stable while out_valid_o && !out_ready_i.
REQ-021 Occupancy states: EMPTY, ONE, FULL (Depth=2); transitions only via push/pop per REQ-014.
REQ-022 busy_o SHALL equal out_valid_o.

Reset
REQ-023 rst_i high SHALL on the next edge clear count and pointers; out_valid_o=0, busy_o=0, in_ready_o=1, out_data_intg_o=39'h0.
REQ-024 Reset mid-transfer SHALL drop all stored words; a push in the reset cycle SHALL be discarded.

Configuration
REQ-025 Macro TLUL_DATA_INTEG_ERR_INJ_EN: when defined, inj_i=2'b01 SHALL flip stored bit 0; 2'b11 SHALL flip bits 0 and 1; 2'b10 SHALL flip bit 32; applied once at capture.
REQ-026 When the macro is undefined, inj_i SHALL be ignored and the stored word SHALL always be the clean encoding.

Structure
REQ-027 DataMaxWidth, DataIntgWidth and the entry typedef (39-bit word) SHALL live in tlul_pkg.
REQ-028 Encoding SHALL use one sub-module instance, prim_secded_inv_39_32_enc; no other sub-modules.

Verification
REQ-029 Reset, then push 32'h0 with out_ready_i=1 -> next cycle out_valid_o=1, out_data_intg_o=39'h2A_0000_0000.
REQ-030 Depth=2, out_ready_i=0, push A, B -> in_ready_o=0 after second push; release -> A then B on consecutive cycles, in_ready_o rises after A pops.
REQ-031 Random data, random valid/ready, 10k beats -> scoreboard order match; each output fed to prim_secded_inv_39_32_dec gives err_o=2'b00.
REQ-032 With TLUL_DATA_INTEG_ERR_INJ_EN: inj_i=2'b01 -> decoder err_o=2'b01; inj_i=2'b11 -> err_o=2'b10; without macro -> err_o=2'b00.
REQ-033 Assert rst_i while FULL with out_ready_i=0 -> next cycle out_valid_o=0, in_ready_o=1, prior words never emitted.
REQ-034 Depth=1, continuous valid and ready -> one word per cycle throughput, in_ready_o held high.
